instr_encoder_loader: RTL

// Encoder side of the control decoder: packs a mnemonic ID plus operand fields

---
 rtl/instr_encoder_loader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// LEGv8 instruction encoder that streams packed words into instruction memory
// at an auto-incrementing byte address, rejecting out-of-range operand fields.
module instr_encoder_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [4:0]        i_id,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rn,
  input  logic [4:0]        i_rm,
  input  logic [31:0]       i_imm,
  input  logic [3:0]        i_cond,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_err,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_count
);

  typedef enum logic [0:0] {RUN = 1'b0, DONE = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(4 * (DEPTH - 1));
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(32'd4);
  localparam logic [ADDR_W-1:0] CNT_STEP  = ADDR_W'(32'd1);

  state_t              state_q;
  logic                valid_q;
  logic [31:0]         instr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   count_q;
  logic                err_q;
  logic                done_q;

  logic                accept_s;
  logic                complete_s;
  logic                last_s;
  logic                load_s;
  logic [32:0]         enc_s;

  // Returns {legal, word}; immediates are range-checked before truncation.
  function automatic logic [32:0] encode(input logic [4:0] id, input logic [4:0] rd,
                                         input logic [4:0] rn, input logic [4:0] rm,
                                         input logic [31:0] imm, input logic [3:0] cond);
    logic signed [31:0] simm;
    logic               ok;
    logic [31:0]        w;
    logic               ok_d, ok_b, ok_cb;
    simm  = $signed(imm);
    ok    = 1'b1;
    w     = 32'h0000_0000;
    ok_d  = (simm >= -32'sd256) && (simm <= 32'sd255);
    ok_b  = (simm >= -32'sd33554432) && (simm <= 32'sd33554431);
    ok_cb = (simm >= -32'sd262144) && (simm <= 32'sd262143);
    case (id)
      5'd0:  w = {11'b10001011000, rm, 6'd0, rn, rd};
      5'd1:  w = {11'b11001011000, rm, 6'd0, rn, rd};
      5'd2:  w = {11'b10001010000, rm, 6'd0, rn, rd};
      5'd3:  w = {11'b10101010000, rm, 6'd0, rn, rd};
      5'd4:  begin ok = (imm[31:6] == 26'd0); w = {11'b11010011011, 5'd0, imm[5:0], rn, rd}; end
      5'd5:  begin ok = (imm[31:6] == 26'd0); w = {11'b11010011010, 5'd0, imm[5:0], rn, rd}; end
      5'd6:  w = {11'b10101011000, rm, 6'd0, rn, rd};
      5'd7:  w = {11'b11101011000, rm, 6'd0, rn, rd};
      5'd8:  w = {11'b11010110000, 5'd0, 6'd0, rn, 5'd0};
      5'd9:  begin ok = (imm[31:12] == 20'd0); w = {10'b1001000100, imm[11:0], rn, rd}; end
      5'd10: begin ok = (imm[31:12] == 20'd0); w = {10'b1101000100, imm[11:0], rn, rd}; end
      5'd11: begin ok = (imm[31:12] == 20'd0); w = {10'b1111000100, imm[11:0], rn, rd}; end
      5'd12: begin ok = ok_d; w = {11'b11111000000, imm[8:0], 2'b00, rn, rd}; end
      5'd13: begin ok = ok_d; w = {11'b11111000010, imm[8:0], 2'b00, rn, rd}; end
      5'd14: begin ok = ok_b; w = {6'b000101, imm[25:0]}; end
      5'd15: begin ok = ok_b; w = {6'b100101, imm[25:0]}; end
      5'd16: begin ok = ok_cb; w = {8'b01010100, imm[18:0], 1'b0, cond}; end
      5'd17: begin ok = ok_cb; w = {8'b10110100, imm[18:0], rd}; end
      5'd18: begin ok = ok_cb; w = {8'b10110101, imm[18:0], rd}; end
      default: ok = 1'b0;
    endcase
    return {ok, w};
  endfunction

  assign o_ready    = (state_q == RUN) && (!valid_q || i_ready);
  assign accept_s   = i_valid && o_ready;
  assign complete_s = valid_q && i_ready;
  assign last_s     = (addr_q == LAST_ADDR);
  // A word accepted on the cycle memory fills has nowhere to go and is dropped.
  assign load_s     = accept_s && !(complete_s && last_s);
  assign enc_s      = encode(i_id, i_rd, i_rn, i_rm, i_imm, i_cond);

  // Load FSM: handshake, write tracking and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      instr_q <= 32'h0000_0000;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (complete_s) begin
            valid_q <= 1'b0;
            addr_q  <= addr_q + ADDR_STEP;
            count_q <= count_q + CNT_STEP;
            if (last_s) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
          if (load_s) begin
            if (enc_s[32]) begin
              instr_q <= enc_s[31:0];
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= RUN;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid = valid_q;
  assign o_instr = instr_q;
  assign o_addr  = addr_q;
  assign o_count = count_q;
  assign o_err   = err_q;
  assign o_done  = done_q;

endmodule
